// File: rtl/riscv_aes_result_writeback.sv
// Captures the AES ciphertext on the cipher's done strobe and writes it as four words into the register file.
// Build option AES_WB_BYTESWAP_EN: byte-reverse each written word (little-endian core, DATA_WIDTH=32).
module riscv_aes_result_writeback #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aes_done_i,
    input  logic [4*DATA_WIDTH-1:0] aes_data_i,
    input  logic                    wready_i,
    input  logic                    clr_overrun_i,
    output logic [ADDR_WIDTH-1:0]   waddr_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic                    wen_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overrun_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [4*DATA_WIDTH-1:0] blk_q, blk_d;
    logic                    ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0]   word_sel;
    logic [DATA_WIDTH-1:0]   word_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            blk_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        ovr_d   = ovr_q;
        if (clr_overrun_i) begin
            ovr_d = 1'b0;
        end
        // A done strobe arriving while busy is dropped; flag it instead.
        if (aes_done_i && state_q != IDLE) begin
            ovr_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (aes_done_i) begin
                    blk_d   = aes_data_i;
                    cnt_d   = 2'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wready_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // word0 sits in the most significant bits of the captured block
    always_comb begin
        word_sel = '0;
        case (cnt_q)
            2'd0: word_sel = blk_q[4*DATA_WIDTH-1 -: DATA_WIDTH];
            2'd1: word_sel = blk_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
            2'd2: word_sel = blk_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
            2'd3: word_sel = blk_q[DATA_WIDTH-1 -: DATA_WIDTH];
            default: word_sel = '0;
        endcase
    end

`ifdef AES_WB_BYTESWAP_EN
    assign word_out = {word_sel[7:0], word_sel[15:8], word_sel[23:16], word_sel[31:24]};
`else
    assign word_out = word_sel;
`endif

    // All outputs decode straight from flops, so they are quiet during the cycle.
    assign wen_o     = (state_q == WRITE);
    assign waddr_o   = wen_o ? BASE + ADDR_WIDTH'(cnt_q) : '0;
    assign wdata_o   = wen_o ? word_out : '0;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_riscv_aes_result_writeback.sv
`timescale 1ns/1ps
module tb_riscv_aes_result_writeback;

    logic         clk = 1'b0;
    logic         rst;
    logic         aes_done;
    logic [127:0] aes_data;
    logic         wready;
    logic         clr;

    logic [1:0]   waddr [2];
    logic [31:0]  wdata [2];
    logic         wen   [2];
    logic         busy  [2];
    logic         done  [2];
    logic         ovr   [2];

    always #5 clk = ~clk;

    riscv_aes_result_writeback #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .aes_done_i(aes_done), .aes_data_i(aes_data),
        .wready_i(wready), .clr_overrun_i(clr),
        .waddr_o(waddr[0]), .wdata_o(wdata[0]), .wen_o(wen[0]),
        .busy_o(busy[0]), .done_o(done[0]), .overrun_o(ovr[0])
    );

    riscv_aes_result_writeback #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .BASE_ADDR(3)) dut3 (
        .clk(clk), .rst(rst), .aes_done_i(aes_done), .aes_data_i(aes_data),
        .wready_i(wready), .clr_overrun_i(clr),
        .waddr_o(waddr[1]), .wdata_o(wdata[1]), .wen_o(wen[1]),
        .busy_o(busy[1]), .done_o(done[1]), .overrun_o(ovr[1])
    );

    typedef struct packed {
        logic [1:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: words still to be written, done pulse due, sticky overrun.
    int m_left = 0;
    bit m_done = 1'b0;
    bit m_ovr  = 1'b0;

    localparam logic [127:0] BLK  = {32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    localparam logic [127:0] ONES = {128{1'b1}};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [127:0] blk, input int k);
        logic [127:0] s;
        logic [31:0]  w;
        s = blk >> (32 * (3 - k));
        w = s[31:0];
`ifdef AES_WB_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic cyc(input bit d, input logic [127:0] data, input bit r, input bit c);
        bit  busy_now;
        bit  ovr_n;
        wr_t e;
        @(negedge clk);
        aes_done = d;
        aes_data = data;
        wready   = r;
        clr      = c;
        busy_now = (m_left > 0) || m_done;
        ovr_n    = (d && busy_now) ? 1'b1 : (c ? 1'b0 : m_ovr);
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (r) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end
        end else if (d) begin
            m_left = 4;
            for (int k = 0; k < 4; k++) begin
                e.d = model_word(data, k);
                e.a = 2'(k % 4);
                q0.push_back(e);
                e.a = 2'((3 + k) % 4);
                q1.push_back(e);
            end
        end
        m_ovr = ovr_n;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aes_done = 1'b0;
        wready   = 1'b1;
        clr      = 1'b0;
        rst      = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_wen",   64'(wen[i]),   64'd0);
            chk("rst_waddr", 64'(waddr[i]), 64'd0);
            chk("rst_wdata", 64'(wdata[i]), 64'd0);
            chk("rst_busy",  64'(busy[i]),  64'd0);
            chk("rst_done",  64'(done[i]),  64'd0);
            chk("rst_ovr",   64'(ovr[i]),   64'd0);
        end
        m_left = 0;
        m_done = 1'b0;
        m_ovr  = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Per-cycle state checks, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk("busy",    64'(busy[i]), 64'((m_left > 0) || m_done));
                chk("done",    64'(done[i]), 64'(m_done));
                chk("overrun", 64'(ovr[i]),  64'(m_ovr));
            end
        end
    end

    // Write-port monitor: handshake is stable once the inputs are driven on the falling edge.
    logic        p_stall [2];
    logic [1:0]  p_a     [2];
    logic [31:0] p_d     [2];

    always @(negedge clk) begin
        wr_t e;
        bit  have;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                p_stall[i] = 1'b0;
            end else begin
                if (p_stall[i]) begin
                    chk("hold_wen",   64'(wen[i]),   64'd1);
                    chk("hold_waddr", 64'(waddr[i]), 64'(p_a[i]));
                    chk("hold_wdata", 64'(wdata[i]), 64'(p_d[i]));
                end
                if (!wen[i]) begin
                    chk("idle_waddr", 64'(waddr[i]), 64'd0);
                    chk("idle_wdata", 64'(wdata[i]), 64'd0);
                end else if (wready) begin
                    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (!have) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write dut%0d: addr %h data %h, no write expected", i, waddr[i], wdata[i]);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk("waddr", 64'(waddr[i]), 64'(e.a));
                        chk("wdata", 64'(wdata[i]), 64'(e.d));
                    end
                end
                p_stall[i] = wen[i] && !wready;
                p_a[i]     = waddr[i];
                p_d[i]     = wdata[i];
            end
        end
    end

    initial begin
        rst      = 1'b1;
        aes_done = 1'b0;
        aes_data = '0;
        wready   = 1'b0;
        clr      = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("init_wen",  64'(wen[i]),  64'd0);
            chk("init_busy", 64'(busy[i]), 64'd0);
            chk("init_ovr",  64'(ovr[i]),  64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // basic: full-rate writes
        cyc(1'b1, BLK, 1'b1, 1'b0);
        repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);

        // backpressure on word 1 for three cycles
        cyc(1'b1, BLK, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);

        // overrun, clear, then set and clear together
        cyc(1'b1, BLK, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, ONES, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, BLK, 1'b1, 1'b0);
        cyc(1'b1, ONES, 1'b1, 1'b1);
        repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // reset in the middle of a block
        cyc(1'b1, BLK, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

        // randomized traffic
        repeat (400) begin
            cyc($urandom_range(0, 3) == 0,
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0);
        end

        repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
